// File: rtl/alu_md.sv
`default_nettype none
// ============================================================================
//  Module      : alu_md
//  Description : Single-issue ALU with iterative multiply/divide unit.
//                Base ops complete in one cycle; multiply/divide run a
//                radix-2 shift-add / restoring-subtract loop on operand
//                magnitudes, then apply sign and hi/lo or quo/rem select.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_md #(
    parameter int XLEN = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         A,
    input  logic [XLEN-1:0]         B,
    input  logic [$clog2(XLEN)-1:0] ShAmt,
    input  logic [4:0]              ALUFn,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         R,
    output logic                    CF,
    output logic                    ZF,
    output logic                    VF,
    output logic                    SF
);

    localparam int            CW         = $clog2(XLEN);
    localparam logic [CW-1:0] c_CNT_INIT = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a, r_md, r_hi, r_lo, r_r;
    logic              r_neg_a, r_neg_b, r_bz;
    logic              r_cf, r_zf, r_vf, r_sf;

    // ---------------- base-op datapath (operates on live inputs) ----------
    logic              w_sub;
    logic [XLEN-1:0]   w_addb, w_res, w_sra, w_base_r;
    logic [XLEN:0]     w_sum;
    logic              w_cf, w_zf, w_vf, w_sf;

    assign w_sub  = (ALUFn[3:0] == 4'b0001) || (ALUFn[3:0] == 4'b1101) ||
                    (ALUFn[3:0] == 4'b1111);
    assign w_addb = w_sub ? ~B : B;
    assign w_sum  = {1'b0, A} + {1'b0, w_addb} + {{XLEN{1'b0}}, w_sub};
    assign w_res  = w_sum[XLEN-1:0];
    assign w_cf   = w_sum[XLEN];
    assign w_zf   = (w_res == '0);
    assign w_sf   = w_res[XLEN-1];
    assign w_vf   = (A[XLEN-1] == w_addb[XLEN-1]) && (w_res[XLEN-1] != A[XLEN-1]);
    assign w_sra  = $signed(A) >>> ShAmt;

    // Base result mux; unlisted codes produce zero
    always_comb begin
        w_base_r = '0;
        case (ALUFn[3:0])
            4'b0000, 4'b0001: w_base_r = w_res;
            4'b0011:          w_base_r = B;
            4'b0100:          w_base_r = A | B;
            4'b0101:          w_base_r = A & B;
            4'b0111:          w_base_r = A ^ B;
            4'b1000:          w_base_r = A >> ShAmt;
            4'b1001:          w_base_r = A << ShAmt;
            4'b1010:          w_base_r = w_sra;
            4'b1101:          w_base_r = {{(XLEN-1){1'b0}}, w_sf ^ w_vf};
            4'b1111:          w_base_r = {{(XLEN-1){1'b0}}, ~w_cf};
            default:          w_base_r = '0;
        endcase
    end

    // ---------------- M-op operand conditioning ----------------------------
    // A is unsigned for MULHU/DIVU/REMU; B is unsigned for MULHSU/MULHU/DIVU/REMU
    logic            w_a_sgn, w_b_sgn, w_neg_a, w_neg_b;
    logic [XLEN-1:0] w_mag_a, w_mag_b;

    assign w_a_sgn = ~(ALUFn[0] & (ALUFn[1] | ALUFn[2]));
    assign w_b_sgn = ~((~ALUFn[2] & ALUFn[1]) | (ALUFn[2] & ALUFn[0]));
    assign w_neg_a = w_a_sgn & A[XLEN-1];
    assign w_neg_b = w_b_sgn & B[XLEN-1];
    assign w_mag_a = w_neg_a ? -A : A;
    assign w_mag_b = w_neg_b ? -B : B;

    // ---------------- iteration step logic ---------------------------------
    logic [XLEN:0]   w_madd, w_shl, w_diff;
    logic            w_ge;

    assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_md} : '0);
    assign w_shl  = {r_hi, r_lo[XLEN-1]};
    assign w_diff = w_shl - {1'b0, r_md};
    assign w_ge   = ~w_diff[XLEN];

    // ---------------- final sign fix and result select ----------------------
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo, w_rem, w_mres;

    assign w_prod_s = (r_neg_a ^ r_neg_b) ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo    = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
    assign w_rem    = r_neg_a ? -r_hi : r_hi;

    // Divide-by-zero bypasses the loop result with fixed RV32M values
    always_comb begin
        w_mres = '0;
        case (r_op)
            3'b000:         w_mres = w_prod_s[XLEN-1:0];
            3'b100, 3'b101: w_mres = r_bz ? '1 : w_quo;
            3'b110, 3'b111: w_mres = r_bz ? r_a : w_rem;
            default:        w_mres = w_prod_s[2*XLEN-1:XLEN];
        endcase
    end

    // ---------------- control FSM -------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_next = ALUFn[4] ? BUSY : DONE;
            BUSY: if (r_cnt == '0) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    // Operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_md    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_bz    <= 1'b0;
            r_r     <= '0;
            r_cf    <= 1'b0;
            r_zf    <= 1'b0;
            r_vf    <= 1'b0;
            r_sf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    if (!ALUFn[4]) begin
                        r_r  <= w_base_r;
                        r_cf <= w_cf;
                        r_zf <= w_zf;
                        r_vf <= w_vf;
                        r_sf <= w_sf;
                    end else begin
                        r_op    <= ALUFn[2:0];
                        r_a     <= A;
                        r_neg_a <= w_neg_a;
                        r_neg_b <= w_neg_b;
                        r_bz    <= (B == '0);
                        r_cnt   <= c_CNT_INIT;
                        r_hi    <= '0;
                        // Divide shifts the dividend through lo; multiply shifts the multiplier
                        r_lo    <= ALUFn[2] ? w_mag_a : w_mag_b;
                        r_md    <= ALUFn[2] ? w_mag_b : w_mag_a;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                    if (r_op[2]) begin
                        r_hi <= w_ge ? w_diff[XLEN-1:0] : w_shl[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_ge};
                    end else begin
                        r_hi <= w_madd[XLEN:1];
                        r_lo <= {w_madd[0], r_lo[XLEN-1:1]};
                    end
                end
                FIX: begin
                    r_r  <= w_mres;
                    r_zf <= (w_mres == '0);
                    r_sf <= w_mres[XLEN-1];
                    r_cf <= 1'b0;
                    r_vf <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign R  = r_r;
    assign CF = r_cf;
    assign ZF = r_zf;
    assign VF = r_vf;
    assign SF = r_sf;

endmodule
`default_nettype wire

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving operand/result width (≥8, power of two).
REQ-002 The block SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, synchronous, active-low; one clock, no other clock domain.
REQ-004 in_valid  in  1  operation request.
REQ-005 in_ready  out  1  block can accept a request.
REQ-006 A, B  in  XLEN each  operands.
REQ-007 ShAmt  in  $clog2(XLEN)  shift amount.
REQ-008 ALUFn  in  5  operation code (bit 4 = 1 selects multiply/divide).
REQ-009 out_valid  out  1  R and flags hold a valid result.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 R  out  XLEN  result; CF, ZF, VF, SF  out  1 each  carry, zero, overflow, sign.

Function
REQ-012 Base codes (bit4=0) SHALL be: 0000 ADD, 0001 SUB, 0011 pass B, 0100 OR, 0101 AND, 0111 XOR, 1000 SRL, 1001 SLL, 1010 SRA, 1101 SLT, 1111 SLTU; any other base code SHALL yield R=0.
REQ-013 M codes (bit4=1, bits3 ignored) by ALUFn[2:0] SHALL be: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU, per RV32M semantics at width XLEN.
REQ-014 SUB, SLT, SLTU SHALL compute A+~B+1 with carry-out CF; SLT = SF xor VF; SLTU = ~CF.
REQ-015 Base-op flags SHALL come from the adder: ZF=(sum==0), SF=sum[XLEN-1], VF=signed overflow of the add/sub, CF=carry-out.
REQ-016 M-op flags SHALL be ZF=(R==0), SF=R[XLEN-1], CF=0, VF=0.
REQ-017 States SHALL be IDLE, BUSY, FIX, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 A request SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; operands and ALUFn SHALL be captured then.
REQ-019 Base op: IDLE -> DONE on acceptance; out_valid SHALL rise one cycle after acceptance.
REQ-020 M op: IDLE -> BUSY with iteration counter = XLEN-1; one shift-add (multiply) or restoring-subtract (divide) step per BUSY cycle on operand magnitudes.
REQ-021 BUSY -> FIX when counter==0; FIX applies sign correction and hi/lo or quotient/remainder select; FIX -> DONE; out_valid SHALL rise exactly XLEN+2 cycles after acceptance.
REQ-022 DONE -> IDLE on an edge with out_ready=1; R and flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 Requests while in_ready=0 SHALL be ignored and SHALL not alter state or captured operands.
REQ-024 Divide by zero SHALL give quotient all-ones (DIV, DIVU) and remainder = A (REM, REMU), with normal latency.
REQ-025 DIV of most-negative by -1 SHALL give quotient = most-negative, REM = 0.
REQ-026 Quotient sign SHALL be A sign xor B sign; remainder sign SHALL follow A.
REQ-027 Shifts SHALL use ShAmt only; SRA SHALL replicate A[XLEN-1].

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE, R=0, all flags 0, out_valid=0, counter=0, and in_ready=1 from the next cycle.
REQ-029 Reset in BUSY, FIX or DONE SHALL abort the operation with no result delivered.
REQ-030 Reset SHALL take priority over acceptance and out_ready in the same cycle.

Verification
REQ-031 ADD A=0x7FFFFFFF, B=1 -> R=0x80000000, VF=1, SF=1, CF=0, ZF=0, out_valid one cycle after acceptance.
REQ-032 MUL A=0xFFFFFFFF, B=3 -> R=0xFFFFFFFD; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000002; out_valid exactly 34 cycles after acceptance.
REQ-033 DIV A=7, B=0 -> 0xFFFFFFFF; REM A=7, B=0 -> 7; DIV A=-7, B=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-034 DIV A=0x80000000, B=0xFFFFFFFF -> R=0x80000000, ZF=0, SF=1; REM same -> R=0, ZF=1.
REQ-035 rst_n=0 on 10th BUSY cycle -> next cycle IDLE, R=0, out_valid=0, in_ready=1; following DIVU 100/7 -> R=14.
REQ-036 out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> R, flags unchanged, in_ready=0, new request not captured.
